// File: rtl/rectangle128_keysched_writer_if.sv
// Host key-load and subkey-memory write signals of the RECTANGLE-128 key schedule writer.
// master = the writer itself, slave = host/memory side.
interface rectangle128_keysched_writer_if;
    logic         start;
    logic [127:0] Key;
    logic         busy;
    logic         done;
    logic         WE;
    logic [4:0]   WAddr;
    logic [63:0]  KeyOut;

    modport master (input start, Key, output busy, done, WE, WAddr, KeyOut);
    modport slave  (output start, Key, input busy, done, WE, WAddr, KeyOut);
endinterface

// File: rtl/rectangle128_keysched_writer.sv
// Iterative RECTANGLE-128 key schedule: one 64-bit subkey written per cycle, NUM_SKEYS in total.
// Optional macro RECTANGLE128_KS_REVERSE_EN writes the subkeys at descending addresses.
module rectangle128_keysched_writer #(
    parameter int         NUM_SKEYS = 26,
    parameter logic [4:0] RC_INIT   = 5'h01
) (
    input  logic                                  Clk,
    input  logic                                  flush,
    rectangle128_keysched_writer_if.master        bus
);
    typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

    localparam logic [4:0] LAST_CNT = 5'(NUM_SKEYS - 1);
    // Entry 0 is the rightmost nibble: S(0)=6 ... S(15)=2.
    localparam logic [15:0][3:0] SBOX = {4'h2, 4'h4, 4'hF, 4'h8, 4'hD, 4'h3, 4'h0, 4'hB,
                                         4'h9, 4'h7, 4'hE, 4'h1, 4'hA, 4'hC, 4'h5, 4'h6};

    state_t           state, state_nxt;
    logic [3:0][31:0] rows;
    logic [4:0]       rc, cnt;
    logic             accept, last;
    logic             we_nxt, done_nxt;
    logic [4:0]       waddr_nxt;
    logic             we_q, done_q;
    logic [4:0]       waddr_q;
    logic [63:0]      keyout_q;

    function automatic logic [63:0] subkey(input logic [3:0][31:0] r);
        return {r[3][15:0], r[2][15:0], r[1][15:0], r[0][15:0]};
    endfunction

    // S-box on the eight low columns, row mixing, then round-constant injection.
    function automatic logic [3:0][31:0] round_fn(input logic [3:0][31:0] r, input logic [4:0] c);
        logic [3:0][31:0] s;
        logic [3:0][31:0] o;
        logic [3:0]       nib;
        s = r;
        for (int j = 0; j < 8; j++) begin
            nib = SBOX[{r[3][j], r[2][j], r[1][j], r[0][j]}];
            for (int k = 0; k < 4; k++) s[k][j] = nib[k];
        end
        o[0]      = {s[0][23:0], s[0][31:24]} ^ s[1];
        o[1]      = s[2];
        o[2]      = s[3];
        o[3]      = {s[3][15:0], s[3][31:16]} ^ s[0];
        o[0][4:0] = o[0][4:0] ^ c;
        return o;
    endfunction

    assign accept = bus.start && (state != GEN);
    assign last   = (cnt == LAST_CNT);

    always_ff @(posedge Clk or posedge flush) begin
        if (flush) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = GEN;
            GEN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = bus.start ? GEN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy  = (state == GEN);
        we_nxt    = (state == GEN);
        done_nxt  = (state == DONE);
`ifdef RECTANGLE128_KS_REVERSE_EN
        waddr_nxt = LAST_CNT - cnt;
`else
        waddr_nxt = cnt;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or posedge flush) begin
        if (flush) begin
            rows <= '0;
            rc   <= RC_INIT;
            cnt  <= '0;
        end else if (accept) begin
            rows <= bus.Key;
            rc   <= RC_INIT;
            cnt  <= '0;
        end else if (state == GEN && !last) begin
            rows <= round_fn(rows, rc);
            rc   <= {rc[3:0], rc[4] ^ rc[2]};
            cnt  <= cnt + 5'd1;
        end
    end

    // Address and data hold their last written values outside GEN.
    always_ff @(posedge Clk or posedge flush) begin
        if (flush) begin
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            waddr_q  <= '0;
            keyout_q <= '0;
        end else begin
            we_q   <= we_nxt;
            done_q <= done_nxt;
            if (we_nxt) begin
                waddr_q  <= waddr_nxt;
                keyout_q <= subkey(rows);
            end
        end
    end

    assign bus.WE     = we_q;
    assign bus.done   = done_q;
    assign bus.WAddr  = waddr_q;
    assign bus.KeyOut = keyout_q;
endmodule

// File: tb/tb_rectangle128_keysched_writer.sv
// Self-checking bench for rectangle128_keysched_writer: spec-level subkey model plus cycle timeline.
// Honours RECTANGLE128_KS_REVERSE_EN when the design is built with it.
module tb_rectangle128_keysched_writer;
    localparam int N = 26;

    logic Clk   = 1'b0;
    logic flush = 1'b0;
    always #5 Clk = ~Clk;

    rectangle128_keysched_writer_if bus();

    rectangle128_keysched_writer dut (
        .Clk  (Clk),
        .flush(flush),
        .bus  (bus)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] data;
    } wr_t;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          writes   = 0;
    int          dones    = 0;
    bit          cmp_en   = 1'b0;
    logic [63:0] exp_sk [N];
    wr_t         exp_q [$];
    bit          exp_we [int];
    bit          exp_busy [int];
    bit          exp_done [int];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int unsigned rotl(input int unsigned x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [4:0] addr_of(input int i);
`ifdef RECTANGLE128_KS_REVERSE_EN
        return 5'(N - 1 - i);
`else
        return 5'(i);
`endif
    endfunction

    // Golden expansion straight from the round rules, on plain integers.
    task automatic model_expand(input logic [127:0] k);
        int unsigned r[4];
        int unsigned s[4];
        int unsigned t[4];
        int unsigned sb[16];
        int unsigned rc, idx, v;
        sb = '{6, 5, 12, 10, 1, 14, 7, 9, 11, 0, 3, 13, 8, 15, 4, 2};
        for (int i = 0; i < 4; i++) r[i] = k[32*i +: 32];
        rc = 1;
        for (int n = 0; n < N; n++) begin
            exp_sk[n] = {16'(r[3]), 16'(r[2]), 16'(r[1]), 16'(r[0])};
            s = r;
            for (int j = 0; j < 8; j++) begin
                idx = ((r[3] >> j) & 1) * 8 + ((r[2] >> j) & 1) * 4
                    + ((r[1] >> j) & 1) * 2 + ((r[0] >> j) & 1);
                v = sb[idx];
                for (int b = 0; b < 4; b++)
                    s[b] = (s[b] & ~(32'd1 << j)) | (((v >> b) & 1) << j);
            end
            t[0] = rotl(s[0], 8) ^ s[1] ^ rc;
            t[1] = s[2];
            t[2] = s[3];
            t[3] = rotl(s[3], 16) ^ s[0];
            rc   = ((rc << 1) & 31) | (((rc >> 4) ^ (rc >> 2)) & 1);
            r    = t;
        end
    endtask

    // A run accepted on edge t: busy t..t+25, writes t+1..t+26, done at t+27.
    task automatic register_run(input logic [127:0] k, input int t);
        wr_t w;
        model_expand(k);
        for (int i = 0; i < N; i++) begin
            w.addr = addr_of(i);
            w.data = exp_sk[i];
            exp_q.push_back(w);
        end
        for (int c = t; c < t + N; c++) exp_busy[c] = 1'b1;
        for (int c = t + 1; c <= t + N; c++) exp_we[c] = 1'b1;
        exp_done[t + N + 1] = 1'b1;
    endtask

    // Called on a negedge; returns on the following negedge with Key scrambled.
    task automatic pulse_start(input logic [127:0] k, input bit accepted);
        bus.Key   = k;
        bus.start = 1'b1;
        if (accepted) register_run(k, cyc + 1);
        @(negedge Clk);
        bus.start = 1'b0;
        bus.Key   = {$urandom, $urandom, $urandom, $urandom};
    endtask

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        wr_t e;
        if (cmp_en) begin
            check("we",   128'(bus.WE),   128'(exp_we.exists(cyc)));
            check("busy", 128'(bus.busy), 128'(exp_busy.exists(cyc)));
            check("done", 128'(bus.done), 128'(exp_done.exists(cyc)));
            if (bus.done) dones++;
            if (bus.WE) begin
                writes++;
                check("write_expected", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("waddr",  128'(bus.WAddr),  128'(e.addr));
                    check("keyout", 128'(bus.KeyOut), 128'(e.data));
                end
            end
        end
    end

    initial begin
        int w0, d0;
        bus.start = 1'b0;
        bus.Key   = '0;
        #1 flush = 1'b1;
        #1;
        check("rst_we",     128'(bus.WE),     128'(0));
        check("rst_busy",   128'(bus.busy),   128'(0));
        check("rst_done",   128'(bus.done),   128'(0));
        check("rst_waddr",  128'(bus.WAddr),  128'(0));
        check("rst_keyout", 128'(bus.KeyOut), 128'(0));

        // Hand-derived values pinning the model.
        model_expand('0);
        check("model_k0_sk0", 128'(exp_sk[0]), 128'(64'h0));
        check("model_k0_sk1", 128'(exp_sk[1]), 128'(64'h0000_0000_00FF_00FE));
        check("model_k0_sk2", 128'(exp_sk[2]), 128'(64'h0000_00FF_0001_00FC));
        model_expand({128{1'b1}});
        check("model_k1_sk0", 128'(exp_sk[0]), 128'(64'hFFFF_FFFF_FFFF_FFFF));

        @(negedge Clk);
        #2 flush = 1'b0;
        cmp_en = 1'b1;
        @(negedge Clk);

        // Zero key, single run.
        w0 = writes; d0 = dones;
        pulse_start('0, 1'b1);
        repeat (30) @(negedge Clk);
        check("t1_writes", 128'(writes - w0), 128'(N));
        check("t1_dones",  128'(dones - d0),  128'(1));

        // start pulses inside GEN, the last one on the final GEN cycle, are ignored.
        w0 = writes; d0 = dones;
        pulse_start(128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0, 1'b1);
        repeat (3) @(negedge Clk);
        pulse_start(128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0);
        repeat (5) @(negedge Clk);
        pulse_start(128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000, 1'b0);
        repeat (15) @(negedge Clk);
        pulse_start(128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF, 1'b0);
        repeat (8) @(negedge Clk);
        check("t2_writes", 128'(writes - w0), 128'(N));
        check("t2_dones",  128'(dones - d0),  128'(1));

        // flush in GEN cycle 10 aborts immediately, then a clean full run.
        w0 = writes; d0 = dones;
        pulse_start(128'hCAFE_F00D_1234_5678_9ABC_DEF0_0F0F_F0F0, 1'b1);
        repeat (10) @(negedge Clk);
        #2 flush = 1'b1;
        exp_q.delete();
        exp_we.delete();
        exp_busy.delete();
        exp_done.delete();
        #1;
        check("fl_we",     128'(bus.WE),     128'(0));
        check("fl_busy",   128'(bus.busy),   128'(0));
        check("fl_done",   128'(bus.done),   128'(0));
        check("fl_keyout", 128'(bus.KeyOut), 128'(0));
        @(negedge Clk);
        #2 flush = 1'b0;
        repeat (30) @(negedge Clk);
        check("t3_writes_aborted", 128'(writes - w0), 128'(10));
        check("t3_no_done",        128'(dones - d0),  128'(0));
        w0 = writes; d0 = dones;
        pulse_start(128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, 1'b1);
        repeat (30) @(negedge Clk);
        check("t3_writes_rerun", 128'(writes - w0), 128'(N));
        check("t3_dones_rerun",  128'(dones - d0),  128'(1));

        // Back-to-back: restart in the DONE cycle with a new key.
        w0 = writes; d0 = dones;
        pulse_start(128'h2468_ACE0_1357_9BDF_FDB9_7531_0ECA_8642, 1'b1);
        repeat (N) @(negedge Clk);
        pulse_start(128'h5A5A_5A5A_A5A5_A5A5_3C3C_3C3C_C3C3_C3C3, 1'b1);
        repeat (32) @(negedge Clk);
        check("t4_writes", 128'(writes - w0), 128'(2 * N));
        check("t4_dones",  128'(dones - d0),  128'(2));

        // All-ones key and a mixed key.
        pulse_start({128{1'b1}}, 1'b1);
        repeat (30) @(negedge Clk);
        pulse_start(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b1);
        repeat (30) @(negedge Clk);

        // Outside GEN the last address and subkey are held.
        check("hold_waddr",  128'(bus.WAddr),  128'(addr_of(N - 1)));
        check("hold_keyout", 128'(bus.KeyOut), 128'(exp_sk[N - 1]));
        check("queue_drained", 128'(exp_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
